// File: rtl/ram_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_resp_ctrl
// Purpose  : Bridges a req/gnt/rvalid memory request port onto a single-port
//            SRAM with a fixed read latency. Full-word writes and reads go
//            straight to the SRAM. Partial-byte writes are turned into a
//            read-modify-write because the SRAM has no byte mask. Addresses
//            beyond the SRAM are answered with an error response and never
//            reach the SRAM.
// Ports    : clk, rst          - clock and synchronous active-high reset
//            req_i / gnt_o     - request handshake (grant only in IDLE)
//            addr_i, we_i,
//            be_i, wdata_i     - request payload (byte address)
//            rvalid_o, rdata_o,
//            err_o             - one response per granted request, in order
//            sram_*            - SRAM control, address and data
// Revision : 1.0 - initial release
// ============================================================================
module ram_resp_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_AW     = 10,
    parameter int RD_LATENCY = 1     // legal range 1..3
) (
    input  logic                    clk,
    input  logic                    rst,
    // request port
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    // response port
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    // SRAM port
    output logic                    sram_cs_o,
    output logic                    sram_we_o,
    output logic [RAM_AW-1:0]       sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;

    // Last RMW_WAIT count value before moving to RMW_WR. The count starts at
    // 1 in the first wait cycle (t+1), so leaving at RD_LATENCY-1 puts the
    // write at t+RD_LATENCY, exactly when the RMW read data arrives.
    localparam logic [1:0] C_CNT_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_WAIT = 2'd1,
        RMW_WR   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic [1:0]              cnt_q,       cnt_d;
    logic [RAM_AW-1:0]       rmw_addr_q,  rmw_addr_d;
    logic [BE_W-1:0]         rmw_be_q,    rmw_be_d;
    logic [DATA_WIDTH-1:0]   rmw_wdata_q, rmw_wdata_d;
    logic                    rmw_done_q,  rmw_done_d;

    // Response pipeline: index 0 is the youngest entry, RD_LATENCY-1 the one
    // presented on the response port this cycle.
    logic [RD_LATENCY-1:0]   pipe_valid_q, pipe_valid_d;
    logic [RD_LATENCY-1:0]   pipe_read_q,  pipe_read_d;
    logic [RD_LATENCY-1:0]   pipe_err_q,   pipe_err_d;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic                    w_oor;
    logic [RAM_AW-1:0]       w_idx;
    logic                    w_be_full;
    logic                    w_be_none;
    logic                    w_unused_addr;

    assign w_idx         = addr_i[RAM_AW+1:2];
    assign w_be_full     = &be_i;
    assign w_be_none     = ~|be_i;
    // Sub-word byte offset has no meaning for a word-wide SRAM.
    assign w_unused_addr = ^addr_i[1:0];

    if (ADDR_WIDTH > RAM_AW + 2) begin : g_oor
        assign w_oor = |addr_i[ADDR_WIDTH-1:RAM_AW+2];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end

    // ------------------------------------------------------------------------
    // RMW byte merge: new bytes where enabled, old SRAM bytes elsewhere
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   w_merge;

    always_comb begin
        w_merge = '0;
        for (int b = 0; b < BE_W; b++) begin
            w_merge[b*8 +: 8] = rmw_be_q[b] ? rmw_wdata_q[b*8 +: 8]
                                            : sram_rdata_i[b*8 +: 8];
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state, SRAM control and pipeline issue
    // ------------------------------------------------------------------------
    logic                    w_issue_valid;
    logic                    w_issue_read;
    logic                    w_issue_err;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rmw_addr_d    = rmw_addr_q;
        rmw_be_d      = rmw_be_q;
        rmw_wdata_d   = rmw_wdata_q;
        rmw_done_d    = 1'b0;
        gnt_o         = 1'b0;
        sram_cs_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        w_issue_valid = 1'b0;
        w_issue_read  = 1'b0;
        w_issue_err   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    if (w_oor) begin
                        // Answered with an error, SRAM untouched.
                        w_issue_valid = 1'b1;
                        w_issue_read  = ~we_i;
                        w_issue_err   = 1'b1;
                    end else if (!we_i) begin
                        sram_cs_o     = 1'b1;
                        sram_addr_o   = w_idx;
                        w_issue_valid = 1'b1;
                        w_issue_read  = 1'b1;
                    end else if (w_be_full) begin
                        sram_cs_o     = 1'b1;
                        sram_we_o     = 1'b1;
                        sram_addr_o   = w_idx;
                        sram_wdata_o  = wdata_i;
                        w_issue_valid = 1'b1;
                    end else if (w_be_none) begin
                        // Nothing to write; still owes a response.
                        w_issue_valid = 1'b1;
                    end else begin
                        // Partial write: fetch the old word, then merge.
                        // Its response comes from rmw_done_q, not the pipe.
                        sram_cs_o   = 1'b1;
                        sram_addr_o = w_idx;
                        rmw_addr_d  = w_idx;
                        rmw_be_d    = be_i;
                        rmw_wdata_d = wdata_i;
                        cnt_d       = 2'd1;
                        state_d     = (RD_LATENCY == 1) ? RMW_WR : RMW_WAIT;
                    end
                end
            end

            RMW_WAIT: begin
                if (cnt_q == C_CNT_LAST) begin
                    state_d = RMW_WR;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            RMW_WR: begin
                sram_cs_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = rmw_addr_q;
                sram_wdata_o = w_merge;
                rmw_done_d   = 1'b1;
                cnt_d        = 2'd0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Response pipeline shift: new entry enters at index 0
    // ------------------------------------------------------------------------
    logic [RD_LATENCY:0]     w_valid_ext;
    logic [RD_LATENCY:0]     w_read_ext;
    logic [RD_LATENCY:0]     w_err_ext;

    always_comb begin
        w_valid_ext  = {pipe_valid_q, w_issue_valid};
        w_read_ext   = {pipe_read_q,  w_issue_read};
        w_err_ext    = {pipe_err_q,   w_issue_err};
        pipe_valid_d = w_valid_ext[RD_LATENCY-1:0];
        pipe_read_d  = w_read_ext[RD_LATENCY-1:0];
        pipe_err_d   = w_err_ext[RD_LATENCY-1:0];
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rmw_addr_q   <= '0;
            rmw_be_q     <= '0;
            rmw_wdata_q  <= '0;
            rmw_done_q   <= 1'b0;
            pipe_valid_q <= '0;
            pipe_read_q  <= '0;
            pipe_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_be_q     <= rmw_be_d;
            rmw_wdata_q  <= rmw_wdata_d;
            rmw_done_q   <= rmw_done_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_read_q  <= pipe_read_d;
            pipe_err_q   <= pipe_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response outputs. Pipeline entries and the RMW completion never land in
    // the same cycle: every entry granted before the partial write has drained
    // by t+RD_LATENCY, and the RMW response appears at t+RD_LATENCY+1.
    // ------------------------------------------------------------------------
    logic                    w_pipe_rv;

    assign w_pipe_rv = pipe_valid_q[RD_LATENCY-1];
    assign rvalid_o  = w_pipe_rv | rmw_done_q;
    assign err_o     = w_pipe_rv & pipe_err_q[RD_LATENCY-1];
    assign rdata_o   = (w_pipe_rv && pipe_read_q[RD_LATENCY-1] && !pipe_err_q[RD_LATENCY-1])
                       ? sram_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_resp_ctrl
// Purpose  : Directed self-checking bench for ram_resp_ctrl with a behavioural
//            two-cycle-latency SRAM (RD_LATENCY=2, RAM_AW=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_resp_ctrl;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        sram_cs_o;
    logic        sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rv_cnt = 0;
    int wr_snap;

    ram_resp_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RAM_AW     (10),
        .RD_LATENCY (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .sram_cs_o    (sram_cs_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: read data appears two cycles after the select.
    // Cycles without a read return a garbage pattern so that any ungated
    // pass-through of sram_rdata_i shows up on rdata_o.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe0;
    logic [31:0] rd_pipe1;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rd_pipe0 = 32'hBAD0_BAD0;
        rd_pipe1 = 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (sram_cs_o === 1'b1 && sram_we_o === 1'b1) mem[sram_addr_o] <= sram_wdata_o;
        rd_pipe0 <= (sram_cs_o === 1'b1 && sram_we_o === 1'b0) ? mem[sram_addr_o] : 32'hBAD0_BAD0;
        rd_pipe1 <= rd_pipe0;
    end
    assign sram_rdata_i = rd_pipe1;

    // Event monitors, sampled before the edge updates the DUT.
    always @(posedge clk) begin
        if (sram_cs_o === 1'b1 && sram_we_o === 1'b1) wr_cnt <= wr_cnt + 1;
        if (rst === 1'b0 && rvalid_o === 1'b1) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, then the caller checks.
    task automatic drv(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        be_i    = b;
        wdata_i = d;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---------------- reset state ----------------
        idle();
        chk("rst_gnt",    {31'd0, gnt_o},     32'd0);
        chk("rst_rvalid", {31'd0, rvalid_o},  32'd0);
        chk("rst_err",    {31'd0, err_o},     32'd0);
        chk("rst_rdata",  rdata_o,            32'd0);
        chk("rst_cs",     {31'd0, sram_cs_o}, 32'd0);
        chk("rst_we",     {31'd0, sram_we_o}, 32'd0);
        chk("rst_addr",   {22'd0, sram_addr_o}, 32'd0);
        chk("rst_wdata",  sram_wdata_o,       32'd0);

        // ---------------- full write then read ----------------
        drv(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        chk("fw_gnt",   {31'd0, gnt_o},     32'd1);
        chk("fw_cs",    {31'd0, sram_cs_o}, 32'd1);
        chk("fw_we",    {31'd0, sram_we_o}, 32'd1);
        chk("fw_addr",  {22'd0, sram_addr_o}, 32'd4);
        chk("fw_wdata", sram_wdata_o,       32'hDEADBEEF);
        drv(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        chk("rd_gnt",   {31'd0, gnt_o},     32'd1);
        chk("rd_cs",    {31'd0, sram_cs_o}, 32'd1);
        chk("rd_we",    {31'd0, sram_we_o}, 32'd0);
        chk("rd_wdata", sram_wdata_o,       32'd0);
        chk("rd_rv0",   {31'd0, rvalid_o},  32'd0);
        idle();
        chk("fw_rv",    {31'd0, rvalid_o},  32'd1);
        chk("fw_rdata", rdata_o,            32'd0);
        chk("fw_err",   {31'd0, err_o},     32'd0);
        idle();
        chk("rd_rv",    {31'd0, rvalid_o},  32'd1);
        chk("rd_rdata", rdata_o,            32'hDEADBEEF);
        idle();
        chk("rd_rv_end", {31'd0, rvalid_o}, 32'd0);

        // ---------------- partial write (RMW) ----------------
        drv(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344);
        idle();
        idle();
        chk("pw_pre_rv", {31'd0, rvalid_o}, 32'd1);
        drv(1'b1, 1'b1, 32'h20, 4'b0010, 32'h0000AA00);          // t
        chk("pw_gnt",    {31'd0, gnt_o},     32'd1);
        chk("pw_rd_cs",  {31'd0, sram_cs_o}, 32'd1);
        chk("pw_rd_we",  {31'd0, sram_we_o}, 32'd0);
        chk("pw_rd_adr", {22'd0, sram_addr_o}, 32'd8);
        drv(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);                     // t+1
        chk("pw_t1_gnt", {31'd0, gnt_o},     32'd0);
        chk("pw_t1_cs",  {31'd0, sram_cs_o}, 32'd0);
        chk("pw_t1_rv",  {31'd0, rvalid_o},  32'd0);
        drv(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);                     // t+2
        chk("pw_t2_gnt", {31'd0, gnt_o},     32'd0);
        chk("pw_t2_cs",  {31'd0, sram_cs_o}, 32'd1);
        chk("pw_t2_we",  {31'd0, sram_we_o}, 32'd1);
        chk("pw_t2_adr", {22'd0, sram_addr_o}, 32'd8);
        chk("pw_merge",  sram_wdata_o,       32'h1122AA44);
        chk("pw_t2_rv",  {31'd0, rvalid_o},  32'd0);
        drv(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);                     // t+3: read granted
        chk("pw_t3_gnt", {31'd0, gnt_o},     32'd1);
        chk("pw_t3_rv",  {31'd0, rvalid_o},  32'd1);
        chk("pw_t3_err", {31'd0, err_o},     32'd0);
        chk("pw_t3_dat", rdata_o,            32'd0);
        idle();
        chk("pw_t4_rv",  {31'd0, rvalid_o},  32'd0);
        idle();
        chk("pw_rb_rv",  {31'd0, rvalid_o},  32'd1);
        chk("pw_rb_dat", rdata_o,            32'h1122AA44);

        // ---------------- out-of-range read ----------------
        drv(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
        chk("oor_gnt",   {31'd0, gnt_o},     32'd1);
        chk("oor_cs",    {31'd0, sram_cs_o}, 32'd0);
        idle();
        chk("oor_rv0",   {31'd0, rvalid_o},  32'd0);
        idle();
        chk("oor_rv",    {31'd0, rvalid_o},  32'd1);
        chk("oor_err",   {31'd0, err_o},     32'd1);
        chk("oor_rdata", rdata_o,            32'd0);

        // ---------------- streaming ----------------
        drv(1'b1, 1'b1, 32'h0, 4'hF, 32'h00000111);
        chk("st_rv_w0",  {31'd0, rvalid_o},  32'd0);
        drv(1'b1, 1'b1, 32'h4, 4'hF, 32'h00000222);
        drv(1'b1, 1'b1, 32'h8, 4'hF, 32'h00000333);
        chk("st_rv_a",   {31'd0, rvalid_o},  32'd1);
        chk("st_wr_dat", rdata_o,            32'd0);
        drv(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        chk("st_rv_b",   {31'd0, rvalid_o},  32'd1);
        drv(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        chk("st_rv_c",   {31'd0, rvalid_o},  32'd1);
        drv(1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        chk("st_gnt",    {31'd0, gnt_o},     32'd1);
        chk("st_d0",     rdata_o,            32'h00000111);
        idle();
        chk("st_d1",     rdata_o,            32'h00000222);
        idle();
        chk("st_rv_d2",  {31'd0, rvalid_o},  32'd1);
        chk("st_d2",     rdata_o,            32'h00000333);
        idle();
        chk("st_rv_end", {31'd0, rvalid_o},  32'd0);

        // ---------------- write with be=0 ----------------
        wr_snap = wr_cnt;
        drv(1'b1, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF);
        chk("be0_gnt",   {31'd0, gnt_o},     32'd1);
        chk("be0_cs",    {31'd0, sram_cs_o}, 32'd0);
        idle();
        chk("be0_rv0",   {31'd0, rvalid_o},  32'd0);
        idle();
        chk("be0_rv",    {31'd0, rvalid_o},  32'd1);
        chk("be0_err",   {31'd0, err_o},     32'd0);
        chk("be0_nowr",  wr_cnt,             wr_snap);

        // ---------------- reset during RMW_WAIT ----------------
        idle();
        wr_snap = wr_cnt;
        drv(1'b1, 1'b1, 32'h30, 4'b0001, 32'h00000055);
        chk("rr_gnt",    {31'd0, gnt_o},     32'd1);
        @(negedge clk);
        rst   = 1'b1;
        req_i = 1'b0;
        #1;
        chk("rr_wait_gnt", {31'd0, gnt_o},   32'd0);
        chk("rr_wait_cs",  {31'd0, sram_cs_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; be_i = 4'hF; wdata_i = 32'h0;
        #1;
        chk("rr_gnt_after", {31'd0, gnt_o},    32'd1);
        chk("rr_rd_we",     {31'd0, sram_we_o}, 32'd0);
        chk("rr_rv_a",      {31'd0, rvalid_o},  32'd0);
        idle();
        chk("rr_rv_b",      {31'd0, rvalid_o},  32'd0);
        chk("rr_we_b",      {31'd0, sram_we_o}, 32'd0);
        idle();
        chk("rr_rd_rv",     {31'd0, rvalid_o},  32'd1);
        chk("rr_rd_dat",    rdata_o,            32'h00000111);
        chk("rr_nowr",      wr_cnt,             wr_snap);

        // ---------------- totals ----------------
        repeat (3) idle();
        chk("tot_rvalid", rv_cnt, 32'd14);
        chk("tot_writes", wr_cnt, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
